// File: rtl/window_line_buffer.sv
// Streaming WIN x WIN sliding-window generator over a raster-scan pixel stream.
// WIN-1 chained line buffers feed the upper window rows; outputs are registered with 1-cycle latency.
module window_line_buffer #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned WIN    = 3,
  localparam int unsigned ColW  = $clog2(IMG_W),
  localparam int unsigned RowW  = $clog2(IMG_H)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_sof,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  output logic [WIN*WIN*DATA_W-1:0]  out_window,
  output logic [RowW-1:0]            out_row,
  output logic [ColW-1:0]            out_col,
  output logic                       out_sof,
  output logic                       out_eof
);

  localparam logic [ColW-1:0] ColFirst = ColW'(WIN - 1);
  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(WIN - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(IMG_H - 1);

  logic [ColW-1:0]   col_q, col_d, pos_col;
  logic [RowW-1:0]   row_q, row_d, pos_row;
  logic [DATA_W-1:0] win_q [WIN][WIN];
  logic [DATA_W-1:0] win_d [WIN][WIN];
  logic [DATA_W-1:0] lb_rd [WIN-1];
  logic [DATA_W-1:0] lb_wr [WIN-1];
  logic              win_ok;

  // A start-of-frame beat overrides the counters so a mid-frame resync lands on (0,0).
  assign pos_col = in_sof ? '0 : col_q;
  assign pos_row = in_sof ? '0 : row_q;
  assign win_ok  = (pos_row >= RowFirst) && (pos_col >= ColFirst);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (pos_col == ColLast) begin
        col_d = '0;
        row_d = (pos_row == RowLast) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  // Line buffer k delays by (k+1) rows: each buffer feeds the next, read-before-write.
  for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
    logic [DATA_W-1:0] mem [IMG_W];

    if (k == 0) begin : g_head
      assign lb_wr[k] = in_data;
    end else begin : g_chain
      assign lb_wr[k] = lb_rd[k-1];
    end

    assign lb_rd[k] = mem[pos_col];

    always_ff @(posedge clk) begin
      if (in_valid) mem[pos_col] <= lb_wr[k];
    end
  end

  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) win_d[r][c] = win_q[r][c+1];
      end
      // Top row takes the longest-delayed buffer.
      for (int r = 0; r < WIN - 1; r++) win_d[r][WIN-1] = lb_rd[WIN-2-r];
      win_d[WIN-1][WIN-1] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) win_q[r][c] <= '0;
      end
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_q     <= win_d;
      out_valid <= in_valid && win_ok;
      out_sof   <= in_valid && (pos_row == RowFirst) && (pos_col == ColFirst);
      out_eof   <= in_valid && (pos_row == RowLast) && (pos_col == ColLast);
      if (in_valid) begin
        out_row <= pos_row;
        out_col <= pos_col;
      end
    end
  end

  always_comb begin
    out_window = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) out_window[(r*WIN+c)*DATA_W +: DATA_W] = win_q[r][c];
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer on an 8x6 image with a 3x3 window.
// Pixel value = offset + row*16 + col; expected windows are computed from that formula.
module tb_window_line_buffer;

  localparam int DW = 17;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int WN = 3;
  localparam int WB = WN * WN * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [WB-1:0] out_window;
  logic [2:0]    out_row;
  logic [2:0]    out_col;
  logic          out_sof;
  logic          out_eof;

  int nchk = 0;
  int nfail = 0;
  int acc_cnt = 0;

  int          q_row[$];
  int          q_col[$];
  int          q_acc[$];
  logic [WB-1:0] q_win[$];
  bit          q_sof[$];
  bit          q_eof[$];

  window_line_buffer #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .WIN(WN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_window(out_window), .out_row(out_row), .out_col(out_col),
    .out_sof(out_sof), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  function automatic logic [WB-1:0] exp_win(input int br, input int bc, input int off);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < WN; r++)
      for (int c = 0; c < WN; c++)
        w[(r*WN+c)*DW +: DW] = DW'(off + (br - 2 + r) * 16 + (bc - 2 + c));
    return w;
  endfunction

  function automatic int pix(input int r, input int c, input int off);
    return off + r * 16 + c;
  endfunction

  // One clock beat; records any valid window the beat produces.
  task automatic beat(input logic v, input logic s, input int d);
    in_valid = v;
    in_sof = s;
    in_data = DW'(d);
    @(posedge clk);
    #1;
    if (v) acc_cnt++;
    if (out_valid) begin
      q_row.push_back(int'(out_row));
      q_col.push_back(int'(out_col));
      q_acc.push_back(acc_cnt);
      q_win.push_back(out_window);
      q_sof.push_back(out_sof);
      q_eof.push_back(out_eof);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic clear_q();
    q_row.delete(); q_col.delete(); q_acc.delete();
    q_win.delete(); q_sof.delete(); q_eof.delete();
    acc_cnt = 0;
  endtask

  task automatic send_frame(input int off, input bit sof);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        beat(1'b1, sof && r == 0 && c == 0, pix(r, c, off));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    nchk++;
    if ({out_valid, out_sof, out_eof, out_row, out_col} !== '0 || out_window !== '0) begin
      nfail++;
      $display("FAIL reset_state: valid=%0b sof=%0b eof=%0b row=%0d col=%0d win=%0h want all 0",
               out_valid, out_sof, out_eof, out_row, out_col, out_window);
    end
    repeat (2) @(posedge clk);
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_frame();
    int k;
    clear_q();
    send_frame(0, 1'b1);
    nchk++;
    if (q_row.size() != 24) begin
      nfail++;
      $display("FAIL frame_count: got %0d windows want 24", q_row.size());
    end
    if (q_row.size() > 0) begin
      nchk++;
      if (q_acc[0] != 19 || q_row[0] != 2 || q_col[0] != 2 || q_sof[0] !== 1'b1) begin
        nfail++;
        $display("FAIL first_window_pos: acc=%0d row=%0d col=%0d sof=%0b want 19/2/2/1",
                 q_acc[0], q_row[0], q_col[0], q_sof[0]);
      end
      nchk++;
      if (q_win[0] !== {17'h22, 17'h21, 17'h20, 17'h12, 17'h11, 17'h10, 17'h02, 17'h01, 17'h00})
      begin
        nfail++;
        $display("FAIL first_window_data: got %0h", q_win[0]);
      end
    end
    k = 0;
    foreach (q_row[i]) begin
      nchk++;
      if (q_row[i] != 2 + k / 6 || q_col[i] != 2 + k % 6 ||
          q_win[i] !== exp_win(2 + k / 6, 2 + k % 6, 0) ||
          q_sof[i] !== (k == 0) || q_eof[i] !== (k == 23)) begin
        nfail++;
        $display("FAIL frame_window[%0d]: row=%0d col=%0d sof=%0b eof=%0b win=%0h want %0d/%0d win=%0h",
                 k, q_row[i], q_col[i], q_sof[i], q_eof[i], q_win[i], 2 + k / 6, 2 + k % 6,
                 exp_win(2 + k / 6, 2 + k % 6, 0));
      end
      k++;
    end
    if (q_win.size() == 24) begin
      nchk++;
      if (q_win[23][8*DW +: DW] !== 17'h57 || q_eof[23] !== 1'b1) begin
        nfail++;
        $display("FAIL eof_bottom_right: got %0h eof=%0b want 57/1", q_win[23][8*DW +: DW],
                 q_eof[23]);
      end
    end
  endtask

  task automatic test_stall();
    logic [WB-1:0] snap;
    int            k;
    clear_q();
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        beat(1'b1, r == 0 && c == 0, pix(r, c, 0));
        snap = out_window;
        for (int n = 0; n < 3 && $urandom_range(0, 1) == 1; n++) begin
          beat(1'b0, 1'b0, 17'h1ffff);
          nchk++;
          if (out_valid !== 1'b0 || out_window !== snap) begin
            nfail++;
            $display("FAIL stall_hold(%0d,%0d): valid=%0b win=%0h want 0 win=%0h",
                     r, c, out_valid, out_window, snap);
          end
        end
      end
    end
    nchk++;
    if (q_row.size() != 24) begin
      nfail++;
      $display("FAIL stall_count: got %0d windows want 24", q_row.size());
    end
    k = 0;
    foreach (q_row[i]) begin
      nchk++;
      if (q_row[i] != 2 + k / 6 || q_col[i] != 2 + k % 6 ||
          q_win[i] !== exp_win(2 + k / 6, 2 + k % 6, 0) || q_eof[i] !== (k == 23)) begin
        nfail++;
        $display("FAIL stall_window[%0d]: row=%0d col=%0d win=%0h", k, q_row[i], q_col[i],
                 q_win[i]);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    int k;
    clear_q();
    send_frame(0, 1'b1);
    send_frame(32'h100, 1'b0);
    nchk++;
    if (q_row.size() != 48) begin
      nfail++;
      $display("FAIL b2b_count: got %0d windows want 48", q_row.size());
    end
    k = 0;
    for (int i = 24; i < q_row.size(); i++) begin
      nchk++;
      if (q_row[i] != 2 + k / 6 || q_col[i] != 2 + k % 6 ||
          q_win[i] !== exp_win(2 + k / 6, 2 + k % 6, 32'h100) ||
          q_sof[i] !== (k == 0) || q_eof[i] !== (k == 23)) begin
        nfail++;
        $display("FAIL b2b_window[%0d]: row=%0d col=%0d sof=%0b win=%0h want win=%0h", k,
                 q_row[i], q_col[i], q_sof[i], q_win[i], exp_win(2 + k / 6, 2 + k % 6, 32'h100));
      end
      k++;
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 30; i++) beat(1'b1, i == 0, pix(i / IW, i % IW, 0));
    clear_q();
    send_frame(32'h200, 1'b1);
    nchk++;
    if (q_row.size() != 24) begin
      nfail++;
      $display("FAIL abort_count: got %0d windows want 24", q_row.size());
    end
    if (q_row.size() > 0) begin
      nchk++;
      if (q_acc[0] != 19 || q_row[0] != 2 || q_col[0] != 2 || q_sof[0] !== 1'b1 ||
          q_win[0] !== exp_win(2, 2, 32'h200)) begin
        nfail++;
        $display("FAIL abort_first: acc=%0d row=%0d col=%0d win=%0h want 19/2/2 win=%0h",
                 q_acc[0], q_row[0], q_col[0], q_win[0], exp_win(2, 2, 32'h200));
      end
    end
    if (q_row.size() == 24) begin
      nchk++;
      if (q_win[23] !== exp_win(5, 7, 32'h200) || q_eof[23] !== 1'b1) begin
        nfail++;
        $display("FAIL abort_last: win=%0h eof=%0b", q_win[23], q_eof[23]);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20; i++) beat(1'b1, i == 0, pix(i / IW, i % IW, 32'h300));
    nchk++;
    if (out_valid !== 1'b1) begin
      nfail++;
      $display("FAIL pre_reset_valid: got %0b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({out_valid, out_sof, out_eof, out_row, out_col} !== '0 || out_window !== '0) begin
      nfail++;
      $display("FAIL async_reset: valid=%0b row=%0d col=%0d win=%0h want all 0",
               out_valid, out_row, out_col, out_window);
    end
    #2 rst_n = 1'b1;
    clear_q();
    send_frame(32'h400, 1'b0);
    nchk++;
    if (q_row.size() != 24) begin
      nfail++;
      $display("FAIL post_reset_count: got %0d windows want 24", q_row.size());
    end
    if (q_row.size() > 0) begin
      nchk++;
      if (q_acc[0] != 19 || q_row[0] != 2 || q_col[0] != 2 ||
          q_win[0] !== exp_win(2, 2, 32'h400)) begin
        nfail++;
        $display("FAIL post_reset_first: acc=%0d row=%0d col=%0d win=%0h want 19/2/2 win=%0h",
                 q_acc[0], q_row[0], q_col[0], q_win[0], exp_win(2, 2, 32'h400));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_stall();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
